// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and constants for the cache memory-port burst responder.
package pmem_pkg;
    localparam int BEATS = 4;
    localparam int BEAT_W = 64;
    localparam int LINE_W = BEATS * BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int LINE_OFFSET_BITS = 5;
    localparam int BEAT_BYTES = 8;
    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} pmem_state_t;
endpackage

// File: rtl/line_beat_buffer.sv
// line_beat_buffer: line register with full-line load, per-beat write and per-beat read mux.
module line_beat_buffer
    import pmem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [LINE_W-1:0]     line_i,
    input  logic                  wr_en_i,
    input  logic [BEAT_IDX_W-1:0] idx_i,
    input  logic [BEAT_W-1:0]     wr_beat_i,
    output logic [BEAT_W-1:0]     rd_beat_o,
    output logic [LINE_W-1:0]     line_o
);
    line_t line_q, line_d;
    always_comb begin
        line_d = line_q;
        if (load_i)
            line_d = line_i;
        else if (wr_en_i)
            line_d[BEAT_W*int'(idx_i) +: BEAT_W] = wr_beat_i;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            line_q <= '0;
        else
            line_q <= line_d;
    end
    assign rd_beat_o = line_q[BEAT_W*int'(idx_i) +: BEAT_W];
    assign line_o = line_q;
endmodule

// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder: serializes one 256-bit cache line read/write into a 4-beat 64-bit bus burst.
module pmem_burst_responder
    import pmem_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              bus_read,
    output logic              bus_write,
    output logic [31:0]       bus_addr,
    output logic [BEAT_W-1:0] bus_wdata,
    input  logic [BEAT_W-1:0] bus_rdata,
    input  logic              bus_resp
);
    pmem_state_t state_q, state_d;
    beat_idx_t beat_q, beat_d;
    logic [31:0] base_q, base_d;
    logic req;
    logic unused_offset;
    assign unused_offset = ^pmem_address[LINE_OFFSET_BITS-1:0];
    assign req = pmem_read | pmem_write;
    assign bus_read = state_q == RD_BURST;
    assign bus_write = state_q == WR_BURST;
    assign pmem_resp = state_q == RESP;
    assign bus_addr = base_q + 32'(beat_q) * 32'(BEAT_BYTES);
    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        base_d = base_q;
        case (state_q)
            IDLE: if (req) begin
                base_d = {pmem_address[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                beat_d = '0;
                state_d = pmem_write ? WR_BURST : RD_BURST;
            end
            RD_BURST, WR_BURST: if (bus_resp) begin
                beat_d = beat_q + beat_idx_t'(1);
                state_d = beat_q == beat_idx_t'(BEATS - 1) ? RESP : state_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            beat_q <= '0;
            base_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            base_q <= base_d;
        end
    end
    // A read accept leaves the buffer alone; the incoming beats overwrite it slice by slice.
    line_beat_buffer u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (state_q == IDLE && pmem_write),
        .line_i    (pmem_wdata),
        .wr_en_i   (bus_read && bus_resp),
        .idx_i     (beat_q),
        .wr_beat_i (bus_rdata),
        .rd_beat_o (bus_wdata),
        .line_o    (pmem_rdata)
    );
endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder: directed vector table plus hand-written reset, stray-ack and back-to-back sequences.
module tb_pmem_burst_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pmem_read = 1'b0;
    logic pmem_write = 1'b0;
    logic [31:0] pmem_address = '0;
    logic [255:0] pmem_wdata = '0;
    logic [255:0] pmem_rdata;
    logic pmem_resp;
    logic bus_read;
    logic bus_write;
    logic [31:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata = '0;
    logic bus_resp = 1'b0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [255:0] rb;
        int           waits;
        logic [31:0]  base;
        int           resp_cyc;
        logic [255:0] rdata;
    } vec_t;

    vec_t vt [4];

    always #5 clk = ~clk;

    pmem_burst_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .bus_read     (bus_read),
        .bus_write    (bus_write),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_resp     (bus_resp)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Starts in an IDLE cycle at a negedge; returns at the negedge of the cycle after RESP.
    task automatic run(input vec_t v, input string tag);
        int cyc = 0;
        int beat = 0;
        int w = 0;
        pmem_read = v.rd;
        pmem_write = v.wr;
        pmem_address = v.addr;
        pmem_wdata = v.line;
        bus_resp = 1'b0;
        while (cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (pmem_resp) break;
            chk({tag, " bus_read"}, bus_read, !v.wr);
            chk({tag, " bus_write"}, bus_write, v.wr);
            if (beat > 3) begin
                chk({tag, " beat count"}, beat, 3);
                break;
            end
            chk({tag, " bus_addr"}, bus_addr, v.base + 32'(beat * 8));
            if (v.wr) chk({tag, " bus_wdata"}, bus_wdata, v.line[64*beat +: 64]);
            bus_resp = w == v.waits;
            bus_rdata = v.rb[64*beat +: 64];
            if (bus_resp) begin
                beat++;
                w = 0;
            end else w++;
        end
        bus_resp = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        chk({tag, " pmem_resp cycle"}, pmem_resp ? cyc : 0, v.resp_cyc);
        chk({tag, " strobes in RESP"}, {bus_read, bus_write}, 2'b00);
        @(negedge clk);
        chk({tag, " pmem_resp single pulse"}, pmem_resp, 1'b0);
        chk({tag, " pmem_rdata"}, pmem_rdata, v.rdata);
    endtask

    initial begin
        vt[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1047, line: '0,
                  rb: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                  waits: 0, base: 32'h0000_1040, resp_cyc: 5,
                  rdata: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
        vt[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_2000,
                  line: 256'hDEAD0004CAFEBEEF_DEAD0003CAFEBEEF_DEAD0002CAFEBEEF_DEAD0001CAFEBEEF,
                  rb: {4{64'hBAD0_BAD0_BAD0_BAD0}},
                  waits: 2, base: 32'h0000_2000, resp_cyc: 13,
                  rdata: 256'hDEAD0004CAFEBEEF_DEAD0003CAFEBEEF_DEAD0002CAFEBEEF_DEAD0001CAFEBEEF};
        vt[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_0300,
                  line: 256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A,
                  rb: {4{64'hBAD1_BAD1_BAD1_BAD1}},
                  waits: 0, base: 32'h0000_0300, resp_cyc: 5,
                  rdata: 256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A};
        vt[3] = '{rd: 1'b1, wr: 1'b0, addr: 32'hFFFF_FFE3, line: '0,
                  rb: 256'hF00D000000000004_F00D000000000003_F00D000000000002_F00D000000000001,
                  waits: 1, base: 32'hFFFF_FFE0, resp_cyc: 9,
                  rdata: 256'hF00D000000000004_F00D000000000003_F00D000000000002_F00D000000000001};

        @(negedge clk);
        chk("reset pmem_resp", pmem_resp, 1'b0);
        chk("reset bus_read", bus_read, 1'b0);
        chk("reset bus_write", bus_write, 1'b0);
        chk("reset bus_addr", bus_addr, 32'h0);
        chk("reset bus_wdata", bus_wdata, 64'h0);
        chk("reset pmem_rdata", pmem_rdata, 256'h0);
        reset_n = 1'b1;

        // Consecutive vectors reassert the request in the cycle right after RESP.
        for (int i = 0; i < 4; i++) run(vt[i], $sformatf("vec%0d", i));

        bus_resp = 1'b1;
        bus_rdata = 64'hBADB_ADBA_DBAD_BADB;
        repeat (2) begin
            @(negedge clk);
            chk("stray strobes", {bus_read, bus_write}, 2'b00);
            chk("stray pmem_resp", pmem_resp, 1'b0);
        end
        bus_resp = 1'b0;
        @(negedge clk);
        chk("stray pmem_rdata", pmem_rdata, vt[3].rdata);
        chk("stray bus_addr", bus_addr, vt[3].base);

        pmem_read = 1'b1;
        pmem_address = 32'h0000_4000;
        @(negedge clk);
        chk("abort bus_read", bus_read, 1'b1);
        chk("abort bus_addr beat0", bus_addr, 32'h0000_4000);
        bus_resp = 1'b1;
        bus_rdata = 64'hAAAA_0000_0000_0001;
        @(negedge clk);
        bus_rdata = 64'hAAAA_0000_0000_0002;
        @(negedge clk);
        chk("abort bus_addr beat2", bus_addr, 32'h0000_4010);
        chk("abort partial line", pmem_rdata[127:0], {64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0001});
        bus_resp = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("abort strobes", {bus_read, bus_write}, 2'b00);
        chk("abort pmem_rdata", pmem_rdata, 256'h0);
        chk("abort bus_addr", bus_addr, 32'h0);
        pmem_read = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort no pmem_resp", pmem_resp, 1'b0);
        end
        reset_n = 1'b1;
        run(vt[0], "after-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
